sha256_msg_sched: RTL and testbench

SHA256_MSG_SCHED -- requirements
Module: sha256_msg_sched

---
 rtl/sha256_pkg.sv | 24 ++
 rtl/sha256_sched_word.sv | 18 +
 rtl/sha256_msg_sched.sv | 91 +++++++++
 tb/tb_sha256_msg_sched.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 message-schedule types, FSM states and the small sigma
// functions used by the schedule expansion.
package sha256_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sched_state_e;

  localparam int SHA256_WORDS_PER_BLOCK = 16;

  // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
  function automatic word_t sigma0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
  function automatic word_t sigma1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_sched_word.sv
// Combinational generator for the next schedule word:
//   new = sigma1(win[14]) + win[9] + sigma0(win[1]) + win[0]  (mod 2^32)
module sha256_sched_word
  import sha256_pkg::*;
(
  input  logic [31:0] i_w14,
  input  logic [31:0] i_w9,
  input  logic [31:0] i_w1,
  input  logic [31:0] i_w0,
  output logic [31:0] o_new
);

  // Four-operand modular add; carries out of bit 31 are dropped by width.
  always_comb begin
    o_new = sigma1(i_w14) + i_w9 + sigma0(i_w1) + i_w0;
  end

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule: accepts a 512-bit block and streams W[0..ROUNDS-1]
// over a valid/ready handshake. A 16-word sliding window holds W[t..t+15];
// win[0] is the word on w_out and each transfer shifts in the next word.
// Optional: define SHA256_SCHED_IDX_EN to add the w_idx round-index port.
module sha256_msg_sched
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         block_valid,
  input  logic [511:0] block,
  output logic         block_ready,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_out,
  output logic         w_last
`ifdef SHA256_SCHED_IDX_EN
 ,output logic [5:0]   w_idx
`endif
);

  localparam logic [5:0] T_LAST = 6'(ROUNDS - 1);

  sched_state_e r_state;
  logic [5:0]   r_t;
  logic [SHA256_WORDS_PER_BLOCK-1:0][31:0] r_win;

  logic [SHA256_WORDS_PER_BLOCK-1:0][31:0] w_ld;
  logic [31:0]  w_new;
  logic         w_xfer;
  logic         w_is_last;

  // Block word M0 sits in the top 32 bits; unpack so that w_ld[0] = M0.
  for (genvar g = 0; g < SHA256_WORDS_PER_BLOCK; g++) begin : g_ld
    assign w_ld[g] = block[511-32*g -: 32];
  end

  sha256_sched_word u_word (
    .i_w14 (r_win[14]),
    .i_w9  (r_win[9]),
    .i_w1  (r_win[1]),
    .i_w0  (r_win[0]),
    .o_new (w_new)
  );

  assign w_valid     = (r_state == ST_RUN);
  assign block_ready = (r_state == ST_IDLE);
  assign w_is_last   = (r_t == T_LAST);
  assign w_last      = w_valid && w_is_last;
  assign w_out       = r_win[0];
  assign w_xfer      = w_valid && w_ready;

`ifdef SHA256_SCHED_IDX_EN
  assign w_idx = r_t;
`endif

  // Load on acceptance, slide the window on each transfer, leave RUN after
  // the last word so a new block can only be taken on the following edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_t     <= '0;
      r_win   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (block_valid) begin
            r_win   <= w_ld;
            r_t     <= '0;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_xfer) begin
            r_win <= {w_new, r_win[SHA256_WORDS_PER_BLOCK-1:1]};
            if (w_is_last) begin
              r_t     <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_t <= r_t + 6'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed bench for sha256_msg_sched: "abc" block, random backpressure,
// back-to-back blocks, reset mid-block and a ROUNDS=16 instance.
module tb_sha256_msg_sched;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         block_valid = 1'b0;
  logic         bv16 = 1'b0;
  logic         w_ready = 1'b0;
  logic         wr16 = 1'b0;
  logic [511:0] block = '0;

  logic         block_ready, w_valid, w_last;
  logic [31:0]  w_out;
  logic         rdy16, val16, last16;
  logic [31:0]  out16;
`ifdef SHA256_SCHED_IDX_EN
  logic [5:0]   w_idx, idx16;
`endif

  int n_tot = 0;
  int n_bad = 0;

  logic [31:0]  mw  [64];
  logic [31:0]  obs [64];
  logic [511:0] abc;
  logic [511:0] blk_b;

  always #5 clk = ~clk;

  sha256_msg_sched #(.ROUNDS(64)) u_dut (
    .clk         (clk),
    .reset       (reset),
    .block_valid (block_valid),
    .block       (block),
    .block_ready (block_ready),
    .w_valid     (w_valid),
    .w_ready     (w_ready),
    .w_out       (w_out),
    .w_last      (w_last)
`ifdef SHA256_SCHED_IDX_EN
   ,.w_idx       (w_idx)
`endif
  );

  sha256_msg_sched #(.ROUNDS(16)) u_dut16 (
    .clk         (clk),
    .reset       (reset),
    .block_valid (bv16),
    .block       (block),
    .block_ready (rdy16),
    .w_valid     (val16),
    .w_ready     (wr16),
    .w_out       (out16),
    .w_last      (last16)
`ifdef SHA256_SCHED_IDX_EN
   ,.w_idx       (idx16)
`endif
  );

  function automatic logic [31:0] s0(input logic [31:0] x);
    return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
  endfunction

  // Reference schedule W[0..63] for a block, straight from the SHA-256 recurrence.
  task automatic build(input logic [511:0] b);
    for (int i = 0; i < 16; i++) mw[i] = b[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      mw[i] = s1(mw[i-2]) + mw[i-7] + s0(mw[i-15]) + mw[i-16];
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Present a block for one cycle; returns at the negedge after acceptance.
  task automatic offer(input logic [511:0] b);
    @(negedge clk);
    block = b;
    block_valid = 1'b1;
    chk("offer_ready", 32'(block_ready), 32'd1);
    @(negedge clk);
    block_valid = 1'b0;
  endtask

  // Entered at the negedge right after acceptance. Consumes all 64 words,
  // optionally stalling randomly, or asserts reset when t reaches abort_at.
  task automatic stream(input logic [511:0] b, input bit stall, input int abort_at);
    int cnt = 0;
    int cyc = 0;
    build(b);
    while (cnt < 64 && cyc < 2000) begin
      if (w_valid !== 1'b1) begin
        chk("w_valid", 32'(w_valid), 32'd1);
        break;
      end
      chk($sformatf("w_out[%0d]", cnt), w_out, mw[cnt]);
      chk($sformatf("w_last[%0d]", cnt), 32'(w_last), 32'(cnt == 63));
`ifdef SHA256_SCHED_IDX_EN
      chk($sformatf("w_idx[%0d]", cnt), 32'(w_idx), 32'(cnt));
`endif
      obs[cnt] = w_out;
      if (cnt == abort_at) begin
        reset = 1'b0;
        #1;
        chk("abort_valid", 32'(w_valid), 32'd0);
        chk("abort_ready", 32'(block_ready), 32'd1);
        chk("abort_out", w_out, 32'd0);
        chk("abort_last", 32'(w_last), 32'd0);
        @(negedge clk);
        chk("abort_hold_valid", 32'(w_valid), 32'd0);
        reset = 1'b1;
        return;
      end
      w_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (w_ready) cnt++;
      cyc++;
      @(negedge clk);
    end
    if (cyc >= 2000) chk("stream_timeout", 32'(cnt), 32'd64);
    w_ready = 1'b0;
    chk("done_valid", 32'(w_valid), 32'd0);
    chk("done_ready", 32'(block_ready), 32'd1);
  endtask

  initial begin
    abc = {32'h61626380, 448'b0, 32'h00000018};
    for (int i = 0; i < 16; i++) blk_b[511-32*i -: 32] = 32'h9e3779b9 * (i + 1) + 32'h1;

    // Reset state
    #2;
    chk("rst_ready", 32'(block_ready), 32'd1);
    chk("rst_valid", 32'(w_valid), 32'd0);
    chk("rst_last", 32'(w_last), 32'd0);
    chk("rst_out", w_out, 32'd0);
`ifdef SHA256_SCHED_IDX_EN
    chk("rst_idx", 32'(w_idx), 32'd0);
`endif
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // "abc" block, no backpressure, plus hand-derived words
    offer(abc);
    stream(abc, 1'b0, -1);
    chk("abc_W0", obs[0], 32'h61626380);
    chk("abc_W15", obs[15], 32'h00000018);
    chk("abc_W16", obs[16], 32'h61626380);
    chk("abc_W17", obs[17], 32'h000F0000);
    chk("abc_W18", obs[18], 32'h7DA86405);

    // Same block under random backpressure
    offer(abc);
    stream(abc, 1'b1, -1);

    // Back-to-back: block_valid held; B offered during RUN must be ignored,
    // then taken on the edge right after the last transfer.
    @(negedge clk);
    block = abc;
    block_valid = 1'b1;
    @(negedge clk);
    block = blk_b;
    stream(abc, 1'b0, -1);
    @(negedge clk);
    block_valid = 1'b0;
    stream(blk_b, 1'b0, -1);

    // Reset at t=30, then a fresh block restarts at W0
    offer(abc);
    stream(abc, 1'b0, 30);
    offer(blk_b);
    stream(blk_b, 1'b0, -1);

    // ROUNDS=16 instance: M0..M15 only, w_last at t=15
    build(blk_b);
    @(negedge clk);
    block = blk_b;
    bv16 = 1'b1;
    @(negedge clk);
    bv16 = 1'b0;
    wr16 = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("r16_valid[%0d]", k), 32'(val16), 32'd1);
      chk($sformatf("r16_out[%0d]", k), out16, mw[k]);
      chk($sformatf("r16_last[%0d]", k), 32'(last16), 32'(k == 15));
`ifdef SHA256_SCHED_IDX_EN
      chk($sformatf("r16_idx[%0d]", k), 32'(idx16), 32'(k));
`endif
      @(negedge clk);
    end
    wr16 = 1'b0;
    chk("r16_done_valid", 32'(val16), 32'd0);
    chk("r16_done_ready", 32'(rdy16), 32'd1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
